// File: rtl/bt_air_pkg.sv
// Shared types and constants for the air-channel model: RX state, delay-line entry, LFSR taps.
package bt_air_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LISTEN = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic       v;
        logic [6:0] fk;
        logic [2:0] sym;
    } dl_entry_t;

    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [6:0]  CHAN_MAX  = 7'd78;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bt_air_channel_if.sv
// Radio-side bundle of the air channel: TX/RX radio signals, register fields and link status.
interface bt_air_channel_if;

    logic        p_1us;
    logic        txen;
    logic [2:0]  txsymbol;
    logic [6:0]  txfk;
    logic        rxen;
    logic [6:0]  rxfk;
    logic [3:0]  regi_delay_us;
    logic [7:0]  regi_settle_us;
    logic [7:0]  regi_ber_th;
    logic        regi_noise_en;
    logic        clr_cnt_p;
    logic [2:0]  rxsymbol;
    logic        rxvalid;
    logic        fk_match;
    logic [15:0] sym_cnt;
    logic [15:0] err_cnt;

    modport master (
        output p_1us, txen, txsymbol, txfk, rxen, rxfk,
               regi_delay_us, regi_settle_us, regi_ber_th, regi_noise_en, clr_cnt_p,
        input  rxsymbol, rxvalid, fk_match, sym_cnt, err_cnt
    );

    modport slave (
        input  p_1us, txen, txsymbol, txfk, rxen, rxfk,
               regi_delay_us, regi_settle_us, regi_ber_th, regi_noise_en, clr_cnt_p,
        output rxsymbol, rxvalid, fk_match, sym_cnt, err_cnt
    );

endinterface

// File: rtl/bt_air_channel_lfsr16.sv
// 16-bit Fibonacci LFSR used as the error/noise source; steps only when i_adv is high.
module bt_air_lfsr16
    import bt_air_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_adv,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_adv) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/bt_air_channel.sv
// Air-interface model: TX symbols pass through a programmable delay line, an RX settle FSM and a
// channel-match gate, with LFSR-driven symbol corruption and noise on unmatched slots.
module bt_air_channel
    import bt_air_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk_6M,
    input  logic              rst,
    bt_air_channel_if.slave   bus
);

    localparam int TAP_W = $clog2(DEPTH);

    function automatic logic [TAP_W-1:0] clamp_tap(input logic [3:0] d);
        if (int'(d) >= DEPTH) begin
            return TAP_W'(DEPTH - 1);
        end
        return TAP_W'(d);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    dl_entry_t        r_line [DEPTH];
    logic [TAP_W-1:0] r_tap;
    rx_state_e        r_state;
    logic [7:0]       r_settle;
    logic [6:0]       r_fk_lat;
    logic             r_vld_p0;
    logic [2:0]       r_rxsymbol;
    logic             r_match;
    logic [15:0]      r_sym_cnt;
    logic [15:0]      r_err_cnt;

    logic [15:0]      w_lfsr;
    dl_entry_t        w_tap;
    logic             w_corrupt;
    logic             w_match;
    logic             w_unused;

    bt_air_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk_6M),
        .rst     (rst),
        .i_adv   (bus.p_1us),
        .o_state (w_lfsr)
    );

    // Symbol-slot stage: shift the delay line and latch the tap index on the strobe.
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_line[i] <= '0;
            end
            r_tap <= '0;
        end else if (bus.p_1us) begin
            r_line[0] <= '{v: bus.txen, fk: bus.txfk, sym: bus.txsymbol};
            for (int i = 1; i < DEPTH; i++) begin
                r_line[i] <= r_line[i-1];
            end
            r_tap <= clamp_tap(bus.regi_delay_us);
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            r_state  <= IDLE;
            r_settle <= '0;
            r_fk_lat <= '0;
        end else if (bus.p_1us) begin
            if (!bus.rxen) begin
                r_state <= IDLE;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_state  <= SETTLE;
                        r_settle <= bus.regi_settle_us;
                        r_fk_lat <= bus.rxfk;
                    end
                    SETTLE: begin
                        if (r_settle <= 8'd1) begin
                            r_state <= LISTEN;
                        end else begin
                            r_settle <= r_settle - 8'd1;
                        end
                    end
                    LISTEN: begin
                        if (bus.rxfk != r_fk_lat) begin
                            r_state  <= SETTLE;
                            r_settle <= bus.regi_settle_us;
                            r_fk_lat <= bus.rxfk;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign w_tap     = r_line[r_tap];
    assign w_corrupt = (w_lfsr[15:8] < bus.regi_ber_th);
    assign w_match   = (r_state == LISTEN) && w_tap.v && (w_tap.fk == bus.rxfk);
    // LFSR middle bits and the channel bound are not consumed by this model.
    assign w_unused  = ^{w_lfsr[7:3], CHAN_MAX};

    // Output stage: one clock after the strobe, using the post-strobe tap, state and LFSR.
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            r_vld_p0   <= 1'b0;
            r_rxsymbol <= '0;
            r_match    <= 1'b0;
        end else begin
            r_vld_p0 <= bus.p_1us;
            if (r_vld_p0) begin
                r_match <= w_match;
                if (w_match) begin
                    r_rxsymbol <= w_tap.sym ^ {2'b00, w_corrupt};
                end else begin
                    r_rxsymbol <= bus.regi_noise_en ? w_lfsr[2:0] : 3'b000;
                end
            end
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rst || bus.clr_cnt_p) begin
            r_sym_cnt <= '0;
            r_err_cnt <= '0;
        end else if (r_vld_p0 && w_match) begin
            r_sym_cnt <= sat_inc(r_sym_cnt);
            if (w_corrupt) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end
        end
    end

    assign bus.rxsymbol = r_rxsymbol;
    assign bus.rxvalid  = r_match;
    assign bus.fk_match = r_match;
    assign bus.sym_cnt  = r_sym_cnt;
    assign bus.err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_bt_air_channel.sv
// Directed bench for bt_air_channel: delay/latency, channel gating, settle gaps, BER counting,
// counter saturation/clear and mid-burst reset, with an independent LFSR reference.
module tb_bt_air_channel;

    logic        clk;
    logic        rst;
    int          n_err;
    int          n_chk;
    logic [15:0] lfsr_m;
    int          cnt;
    int          exp_err;
    logic        got;
    logic        corrupt;

    bt_air_channel_if bus ();

    bt_air_channel #(.DEPTH(16), .LFSR_SEED(16'hACE1)) dut (
        .clk_6M (clk),
        .rst    (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the output stage has updated.
    task automatic strobe();
        bus.p_1us = 1'b1;
        @(negedge clk);
        bus.p_1us = 1'b0;
        lfsr_m = lfsr_step(lfsr_m);
        @(negedge clk);
    endtask

    task automatic clr_pulse();
        bus.clr_cnt_p = 1'b1;
        @(negedge clk);
        bus.clr_cnt_p = 1'b0;
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        lfsr_m = 16'hACE1;
        rst = 1'b1;
        bus.p_1us = 0; bus.txen = 0; bus.txsymbol = 0; bus.txfk = 0;
        bus.rxen = 0; bus.rxfk = 0; bus.regi_delay_us = 0; bus.regi_settle_us = 0;
        bus.regi_ber_th = 0; bus.regi_noise_en = 0; bus.clr_cnt_p = 0;
        repeat (3) @(negedge clk);
        chk("reset_rxvalid", bus.rxvalid, 0);
        chk("reset_rxsymbol", bus.rxsymbol, 0);
        chk("reset_fk_match", bus.fk_match, 0);
        chk("reset_sym_cnt", bus.sym_cnt, 0);
        chk("reset_err_cnt", bus.err_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: delay 3, settle 0, matched channel, symbols 1..7,0
        bus.rxen = 1; bus.rxfk = 7'd10; bus.txfk = 7'd10; bus.regi_delay_us = 4'd3;
        strobe();
        chk("t1_settle_rxvalid", bus.rxvalid, 0);
        strobe();
        for (int m = 0; m < 11; m++) begin
            bus.txen = (m < 8);
            bus.txsymbol = 3'(m + 1);
            if (m == 3) begin
                bus.p_1us = 1'b1;
                @(negedge clk);
                bus.p_1us = 1'b0;
                lfsr_m = lfsr_step(lfsr_m);
                chk("t1_latency_hold", bus.rxvalid, 0);
                @(negedge clk);
            end else begin
                strobe();
            end
            if (m >= 3) begin
                chk("t1_rxvalid", bus.rxvalid, 1);
                chk("t1_fk_match", bus.fk_match, 1);
                chk("t1_rxsymbol", bus.rxsymbol, 32'((m - 2) & 7));
            end else begin
                chk("t1_pre_rxvalid", bus.rxvalid, 0);
            end
        end
        chk("t1_sym_cnt", bus.sym_cnt, 8);
        chk("t1_err_cnt", bus.err_cnt, 0);

        // 2: channel mismatch, noise off then on
        bus.txen = 1; bus.txfk = 7'd12; bus.txsymbol = 3'd5; bus.regi_noise_en = 0;
        repeat (4) strobe();
        for (int i = 0; i < 4; i++) begin
            strobe();
            chk("t2_rxvalid", bus.rxvalid, 0);
            chk("t2_fk_match", bus.fk_match, 0);
            chk("t2_rxsymbol_quiet", bus.rxsymbol, 0);
        end
        bus.regi_noise_en = 1;
        for (int i = 0; i < 4; i++) begin
            strobe();
            chk("t2_rxvalid_noise", bus.rxvalid, 0);
            chk("t2_rxsymbol_noise", bus.rxsymbol, 32'(lfsr_m[2:0]));
        end
        chk("t2_sym_cnt", bus.sym_cnt, 8);

        // 3: settle gap of 150 strobes on rxen rise and on rxfk change
        bus.regi_noise_en = 0; bus.rxen = 0; bus.txfk = 7'd10; bus.txsymbol = 3'd6;
        bus.regi_settle_us = 8'd150;
        repeat (4) strobe();
        chk("t3_idle_rxvalid", bus.rxvalid, 0);
        bus.rxen = 1;
        cnt = 0; got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            strobe();
            if (bus.rxvalid) got = 1; else cnt++;
        end
        chk("t3_rxen_gap", cnt, 150);
        chk("t3_rxsymbol", bus.rxsymbol, 6);
        repeat (2) strobe();
        bus.rxfk = 7'd11; bus.txfk = 7'd11;
        cnt = 0; got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            strobe();
            if (bus.rxvalid) got = 1; else cnt++;
        end
        chk("t3_rxfk_gap", cnt, 150);
        chk("t3_fk_match", bus.fk_match, 1);

        // 4: BER threshold 0xFF against reference LFSR, then threshold 0
        bus.regi_ber_th = 8'hFF;
        clr_pulse();
        chk("t4_clr_sym_cnt", bus.sym_cnt, 0);
        exp_err = 0;
        for (int i = 0; i < 1000; i++) begin
            strobe();
            corrupt = (lfsr_m[15:8] < 8'hFF);
            if (corrupt) exp_err++;
            chk("t4_rxsymbol", bus.rxsymbol, 32'(3'd6 ^ {2'b00, corrupt}));
        end
        chk("t4_sym_cnt", bus.sym_cnt, 1000);
        chk("t4_err_cnt", bus.err_cnt, 32'(exp_err));
        bus.regi_ber_th = 8'h00;
        clr_pulse();
        repeat (20) strobe();
        chk("t4_err_cnt_zero", bus.err_cnt, 0);
        chk("t4_sym_cnt_20", bus.sym_cnt, 20);

        // 5: saturation at 0xFFFF and clear winning over an increment
        clr_pulse();
        bus.p_1us = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            @(negedge clk);
            lfsr_m = lfsr_step(lfsr_m);
        end
        bus.p_1us = 1'b0;
        @(negedge clk);
        chk("t5_sym_cnt_fffe", bus.sym_cnt, 32'hFFFE);
        repeat (3) strobe();
        chk("t5_sym_cnt_sat", bus.sym_cnt, 32'hFFFF);
        chk("t5_err_cnt", bus.err_cnt, 0);
        bus.p_1us = 1'b1;
        @(negedge clk);
        bus.p_1us = 1'b0;
        bus.clr_cnt_p = 1'b1;
        lfsr_m = lfsr_step(lfsr_m);
        @(negedge clk);
        bus.clr_cnt_p = 1'b0;
        chk("t5_clr_wins", bus.sym_cnt, 0);
        strobe();
        chk("t5_after_clr", bus.sym_cnt, 1);

        // 6: reset mid-burst with delay 5
        bus.regi_delay_us = 4'd5; bus.regi_settle_us = 8'd0; bus.regi_noise_en = 1;
        bus.txsymbol = 3'd3;
        repeat (6) strobe();
        chk("t6_pre_rxvalid", bus.rxvalid, 1);
        chk("t6_pre_rxsymbol", bus.rxsymbol, 3);
        rst = 1'b1;
        @(negedge clk);
        lfsr_m = 16'hACE1;
        chk("t6_rst_rxvalid", bus.rxvalid, 0);
        chk("t6_rst_rxsymbol", bus.rxsymbol, 0);
        chk("t6_rst_fk_match", bus.fk_match, 0);
        chk("t6_rst_sym_cnt", bus.sym_cnt, 0);
        chk("t6_rst_err_cnt", bus.err_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            strobe();
            chk("t6_flush_rxvalid", bus.rxvalid, 0);
            chk("t6_flush_noise", bus.rxsymbol, 32'(lfsr_m[2:0]));
        end
        strobe();
        chk("t6_first_rxvalid", bus.rxvalid, 1);
        chk("t6_first_rxsymbol", bus.rxsymbol, 3);
        chk("t6_sym_cnt", bus.sym_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
